// File: rtl/reset_seq_pkg.sv
// Shared definitions for the CPU reset sequencer: state encodings and the
// per-state output vectors {rst_mem, rst_rf, rst_pipe, run_en, seq_busy}.
package reset_seq_pkg;

  typedef logic [2:0] state_t;
  typedef logic [4:0] out_vec_t;

  localparam state_t S_HOLD     = 3'd0;
  localparam state_t S_MEM_INIT = 3'd1;
  localparam state_t S_REL_RF   = 3'd2;
  localparam state_t S_REL_PIPE = 3'd3;
  localparam state_t S_RUN      = 3'd4;
  localparam state_t S_ERR      = 3'd5;

  localparam out_vec_t OUT_HOLD     = 5'b11101;
  localparam out_vec_t OUT_MEM_INIT = 5'b01101;
  localparam out_vec_t OUT_REL_RF   = 5'b00101;
  localparam out_vec_t OUT_REL_PIPE = 5'b00001;
  localparam out_vec_t OUT_RUN      = 5'b00010;
  localparam out_vec_t OUT_ERR      = 5'b11100;

  function automatic out_vec_t state_outputs(input state_t s);
    case (s)
      S_HOLD:     return OUT_HOLD;
      S_MEM_INIT: return OUT_MEM_INIT;
      S_REL_RF:   return OUT_REL_RF;
      S_REL_PIPE: return OUT_REL_PIPE;
      S_RUN:      return OUT_RUN;
      S_ERR:      return OUT_ERR;
      default:    return OUT_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Saturating per-state edge counter; terminal is high on the edge that
// would be the limit-th counted edge.
module seq_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Widened so a saturated count still compares correctly against any limit
  assign terminal = (({1'b0, count_q} + (CNT_W+1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/reset_sequencer.sv
// Releases memory, register-file and pipeline resets in order after the
// master reset drops, then enables the CPU; traps a memory-init timeout.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 2,
  parameter int MEM_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       mem_init_done,
  input  logic       soft_reset_req,
  output logic       rst_mem,
  output logic       rst_rf,
  output logic       rst_pipe,
  output logic       run_en,
  output logic       seq_busy,
  output logic       timeout_err,
  output logic [2:0] state
);

  state_t           state_q, state_d;
  out_vec_t         outs_q, outs_d;
  logic             timeout_q, timeout_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_limit;

  seq_cycle_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (CLK),
    .reset    (Reset),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .limit    (cnt_limit),
    .terminal (cnt_tc)
  );

  always_comb begin
    case (state_q)
      S_HOLD:     cnt_limit = CNT_W'(HOLD_CYCLES);
      S_MEM_INIT: cnt_limit = CNT_W'(MEM_TIMEOUT);
      default:    cnt_limit = CNT_W'(STAGE_GAP);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    if (soft_reset_req) begin
      state_d   = S_HOLD;
      timeout_d = 1'b0;
      cnt_clr   = 1'b1;
    end else begin
      case (state_q)
        S_HOLD: begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = S_MEM_INIT;
            cnt_clr = 1'b1;
          end
        end
        // A done arriving on the timeout edge still counts as success
        S_MEM_INIT: begin
          cnt_en = 1'b1;
          if (mem_init_done) begin
            state_d = S_REL_RF;
            cnt_clr = 1'b1;
          end else if (cnt_tc) begin
            state_d   = S_ERR;
            timeout_d = 1'b1;
            cnt_clr   = 1'b1;
          end
        end
        S_REL_RF: begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = S_REL_PIPE;
            cnt_clr = 1'b1;
          end
        end
        S_REL_PIPE: begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = S_RUN;
            cnt_clr = 1'b1;
          end
        end
        S_RUN, S_ERR: begin
        end
        default: begin
          state_d = S_HOLD;
          cnt_clr = 1'b1;
        end
      endcase
    end
    outs_d = state_outputs(state_d);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_HOLD;
      outs_q    <= OUT_HOLD;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      outs_q    <= outs_d;
      timeout_q <= timeout_d;
    end
  end

  assign {rst_mem, rst_rf, rst_pipe, run_en, seq_busy} = outs_q;
  assign timeout_err = timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed plus randomized bench for reset_sequencer; two instances (default
// and short memory timeout) are checked against an edge-count timeline model.
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       soft_reset_req = 1'b0;
  logic       done_a = 1'b0, done_b = 1'b0;
  logic       mem_a, rf_a, pipe_a, run_a, busy_a, tmo_a;
  logic       mem_b, rf_b, pipe_b, run_b, busy_b, tmo_b;
  logic [2:0] state_a, state_b;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  // Timeline model: edges since last restart, edge of accepted done, error
  int hold_p[2]  = '{4, 4};
  int gap_p[2]   = '{2, 2};
  int tmo_p[2]   = '{1024, 8};
  int n[2]       = '{0, 0};
  int doneAt[2]  = '{-1, -1};
  bit errSt[2]   = '{0, 0};
  bit tmoFlag[2] = '{0, 0};
  bit illegal[2] = '{0, 0};

  always #5 CLK = ~CLK;

  reset_sequencer dut_a (
    .CLK(CLK), .Reset(Reset), .mem_init_done(done_a), .soft_reset_req(soft_reset_req),
    .rst_mem(mem_a), .rst_rf(rf_a), .rst_pipe(pipe_a), .run_en(run_a),
    .seq_busy(busy_a), .timeout_err(tmo_a), .state(state_a)
  );

  reset_sequencer #(.MEM_TIMEOUT(8)) dut_b (
    .CLK(CLK), .Reset(Reset), .mem_init_done(done_b), .soft_reset_req(soft_reset_req),
    .rst_mem(mem_b), .rst_rf(rf_b), .rst_pipe(pipe_b), .run_en(run_b),
    .seq_busy(busy_b), .timeout_err(tmo_b), .state(state_b)
  );

  function automatic logic [4:0] expOuts(input int st);
    case (st)
      0:       return 5'b11101;
      1:       return 5'b01101;
      2:       return 5'b00101;
      3:       return 5'b00001;
      4:       return 5'b00010;
      default: return 5'b11100;
    endcase
  endfunction

  function automatic int expState(input int i);
    int d;
    if (errSt[i]) return 5;
    if (doneAt[i] >= 0) begin
      d = n[i] - doneAt[i];
      if (d < gap_p[i]) return 2;
      if (d < 2 * gap_p[i]) return 3;
      return 4;
    end
    if (n[i] < hold_p[i]) return 0;
    return 1;
  endfunction

  task automatic modelEdge(input int i, input bit r, input bit s, input bit d);
    if (r || s) begin
      n[i] = 0; doneAt[i] = -1; errSt[i] = 1'b0; tmoFlag[i] = 1'b0;
    end else if (illegal[i]) begin
      n[i] = 0; doneAt[i] = -1; errSt[i] = 1'b0;
    end else begin
      n[i]++;
      if (!errSt[i] && doneAt[i] < 0 && n[i] > hold_p[i]) begin
        if (d) doneAt[i] = n[i];
        else if (n[i] - hold_p[i] == tmo_p[i]) begin
          errSt[i] = 1'b1; tmoFlag[i] = 1'b1;
        end
      end
    end
    illegal[i] = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkInstance(input int i);
    int st;
    logic [4:0] eo, oo;
    logic [2:0] os;
    logic ot;
    st = expState(i);
    eo = expOuts(st);
    oo = (i == 0) ? {mem_a, rf_a, pipe_a, run_a, busy_a} : {mem_b, rf_b, pipe_b, run_b, busy_b};
    os = (i == 0) ? state_a : state_b;
    ot = (i == 0) ? tmo_a : tmo_b;
    checkOutput($sformatf("dut%0d.state", i), 8'(os), 8'(st));
    checkOutput($sformatf("dut%0d.rst_mem", i), 8'(oo[4]), 8'(eo[4]));
    checkOutput($sformatf("dut%0d.rst_rf", i), 8'(oo[3]), 8'(eo[3]));
    checkOutput($sformatf("dut%0d.rst_pipe", i), 8'(oo[2]), 8'(eo[2]));
    checkOutput($sformatf("dut%0d.run_en", i), 8'(oo[1]), 8'(eo[1]));
    checkOutput($sformatf("dut%0d.seq_busy", i), 8'(oo[0]), 8'(eo[0]));
    checkOutput($sformatf("dut%0d.timeout_err", i), 8'(ot), 8'(tmoFlag[i]));
  endtask

  // Drive inputs, take one edge, advance the model, check on the falling edge
  task automatic applyStimulus(input bit r, input bit s, input bit da, input bit db);
    Reset = r; soft_reset_req = s; done_a = da; done_b = db;
    @(posedge CLK);
    modelEdge(0, r, s, da);
    modelEdge(1, r, s, db);
    cyc++;
    @(negedge CLK);
    checkInstance(0);
    checkInstance(1);
  endtask

  initial begin
    bit r, s, da, db;
    $display("[TB] start");
    repeat (5) applyStimulus(1, 0, 1, 0);
    // Release with done high on A; B never sees done and must time out
    repeat (14) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    // B: done arrives exactly on its 8th MEM_INIT edge
    repeat (11) applyStimulus(0, 0, 1, 0);
    repeat (11) applyStimulus(0, 0, 1, 1);
    // A: done raised on MEM_INIT edge 100
    repeat (2) applyStimulus(1, 0, 0, 1);
    repeat (103) applyStimulus(0, 0, 0, 1);
    repeat (11) applyStimulus(0, 0, 1, 1);
    // Reset together with soft request while A is in REL_PIPE
    applyStimulus(1, 0, 1, 1);
    repeat (7) applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 1, 1, 1);
    repeat (10) applyStimulus(0, 0, 1, 1);
    // Illegal state injection on A while in RUN
    dut_a.state_q = 3'd6;
    illegal[0] = 1'b1;
    repeat (11) applyStimulus(0, 0, 1, 1);
    // Randomized tail
    da = 1'b0; db = 1'b0;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) da = ~da;
      if ($urandom_range(0, 5) == 0) db = ~db;
      applyStimulus(r, s, da, db);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
